// File: rtl/comp_dict_engine.sv
// Dictionary compression engine: maps symbols to dictionary indices (COMPRESS),
// indices back to symbols (DECOMPRESS), with a sequential one-entry-per-cycle search.
module comp_dict_engine #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DICT_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            command,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] compressed_in,
   output logic [DATA_WIDTH-1:0] compressed_out,
   output logic [DATA_WIDTH-1:0] decompressed_out,
   output logic [1:0]            response,
   output logic                  busy
);

   localparam int unsigned IDX_W = $clog2(DICT_DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned CMP_W = (DATA_WIDTH > CNT_W) ? DATA_WIDTH : CNT_W;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_COMP  = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   localparam logic [1:0] RSP_NONE   = 2'b00;
   localparam logic [1:0] RSP_OK     = 2'b01;
   localparam logic [1:0] RSP_ERROR  = 2'b10;
   localparam logic [1:0] RSP_OK_NEW = 2'b11;

   typedef enum logic [1:0] {IDLE, SEARCH, DECODE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] key_q, key_d;
   logic [DATA_WIDTH-1:0] idx_q, idx_d;
   logic [IDX_W-1:0]      i_q, i_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  busy_d;
   logic [1:0]            response_d;
   logic [DATA_WIDTH-1:0] compressed_d, decompressed_d;
   logic                  dict_we;
   logic [IDX_W-1:0]      dict_waddr;
   logic                  hit, last, in_range, not_full;

   logic [DATA_WIDTH-1:0] dict [DICT_DEPTH];

   assign hit      = (CNT_W'(i_q) < count_q) && (dict[i_q] == key_q);
   assign last     = (count_q == '0) || (CNT_W'(i_q) == (count_q - CNT_W'(1)));
   assign in_range = CMP_W'(idx_q) < CMP_W'(count_q);
   assign not_full = count_q < CNT_W'(DICT_DEPTH);

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         cmd_q            <= CMD_NOP;
         key_q            <= '0;
         idx_q            <= '0;
         i_q              <= '0;
         count_q          <= '0;
         busy             <= 1'b0;
         response         <= RSP_NONE;
         compressed_out   <= '0;
         decompressed_out <= '0;
      end else begin
         state_q          <= state_d;
         cmd_q            <= cmd_d;
         key_q            <= key_d;
         idx_q            <= idx_d;
         i_q              <= i_d;
         count_q          <= count_d;
         busy             <= busy_d;
         response         <= response_d;
         compressed_out   <= compressed_d;
         decompressed_out <= decompressed_d;
      end
   end

   // Storage is deliberately not cleared by reset; count marks validity
   always_ff @(posedge clk) begin
      if (!reset && dict_we) dict[dict_waddr] <= key_q;
   end

   // Next-state and output logic
   always_comb begin
      state_d        = state_q;
      cmd_d          = cmd_q;
      key_d          = key_q;
      idx_d          = idx_q;
      i_d            = i_q;
      count_d        = count_q;
      busy_d         = busy;
      response_d     = RSP_NONE;
      compressed_d   = compressed_out;
      decompressed_d = decompressed_out;
      dict_we        = 1'b0;
      dict_waddr     = IDX_W'(count_q);

      unique case (state_q)
         IDLE: begin
            if (!busy && command != CMD_NOP) begin
               cmd_d   = command;
               key_d   = data_in;
               idx_d   = compressed_in;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = (command == CMD_COMP) ? SEARCH : DECODE;
            end
         end
         SEARCH: begin
            if (hit) begin
               compressed_d = DATA_WIDTH'(i_q);
               response_d   = RSP_OK;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end else if (last) begin
               if (not_full) begin
                  dict_we      = 1'b1;
                  compressed_d = DATA_WIDTH'(count_q);
                  count_d      = count_q + CNT_W'(1);
                  response_d   = RSP_OK_NEW;
               end else begin
                  compressed_d = '0;
                  response_d   = RSP_ERROR;
               end
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               i_d = i_q + IDX_W'(1);
            end
         end
         DECODE: begin
            if (cmd_q == CMD_CLEAR) begin
               count_d    = '0;
               response_d = RSP_OK;
            end else if (in_range) begin
               decompressed_d = dict[IDX_W'(idx_q)];
               response_d     = RSP_OK;
            end else begin
               decompressed_d = '0;
               response_d     = RSP_ERROR;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_comp_dict_engine.sv
// Directed testbench for comp_dict_engine: hand-computed latencies, responses and indices.
module tb_comp_dict_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] command;
   logic [7:0] data_in, compressed_in;
   logic [7:0] compressed_out, decompressed_out;
   logic [1:0] response;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] NOP = 2'b00, COMP = 2'b01, DECOMP = 2'b10, CLR = 2'b11;

   comp_dict_engine #(.DATA_WIDTH(8), .DICT_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .command(command), .data_in(data_in),
      .compressed_in(compressed_in), .compressed_out(compressed_out),
      .decompressed_out(decompressed_out), .response(response), .busy(busy)
   );

   always #5 clk = ~clk;

   // Issue one command and report resolve latency (edges after acceptance) and outputs
   task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic [7:0] ci,
                          output int lat, output logic [1:0] resp, output logic [7:0] cout,
                          output logic [7:0] dout, output logic bsy, output logic [1:0] resp_nx);
      @(negedge clk);
      command = c; data_in = d; compressed_in = ci;
      @(posedge clk); #1;
      command = NOP;
      lat = -1; resp = 2'b00; cout = 8'h00; dout = 8'h00; bsy = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (response !== 2'b00) begin
            lat = k; resp = response; cout = compressed_out; dout = decompressed_out; bsy = busy;
            break;
         end
      end
      @(posedge clk); #1;
      resp_nx = response;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fill(input int n, input logic [7:0] base);
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      for (int k = 0; k < n; k++) run_cmd(COMP, base + 8'(k), 8'h00, lat, r, co, dox, b, rn);
   endtask

   task automatic test_reset();
      command = NOP; data_in = 8'h00; compressed_in = 8'h00; reset = 1'b0;
      do_reset();
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      n_checks++;
      if (response !== 2'b00) begin n_fail++; $display("FAIL reset_response got=%0h exp=0", response); end
      n_checks++;
      if (compressed_out !== 8'h00) begin n_fail++; $display("FAIL reset_cout got=%0h exp=0", compressed_out); end
      n_checks++;
      if (decompressed_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%0h exp=0", decompressed_out); end
      n_checks++;
      if (dut.count_q !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", dut.count_q); end
   endtask

   task automatic test_first_insert();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      run_cmd(COMP, 8'hA5, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 1 || r !== 2'b11 || co !== 8'h00)
         begin n_fail++; $display("FAIL first_insert got lat=%0d resp=%0h cout=%0h exp lat=1 resp=3 cout=0", lat, r, co); end
      n_checks++;
      if (rn !== 2'b00) begin n_fail++; $display("FAIL first_insert_resp_clear got=%0h exp=0", rn); end
      n_checks++;
      if (dut.count_q !== 5'd1) begin n_fail++; $display("FAIL first_insert_count got=%0d exp=1", dut.count_q); end
   endtask

   task automatic test_hit();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      int exp_lat [3] = '{1, 1, 2};
      logic [7:0] syms [3] = '{8'h11, 8'h22, 8'h33};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         run_cmd(COMP, syms[k], 8'h00, lat, r, co, dox, b, rn);
         n_checks++;
         if (lat != exp_lat[k] || r !== 2'b11 || co !== 8'(k))
            begin n_fail++; $display("FAIL insert_%0d got lat=%0d resp=%0h cout=%0h exp lat=%0d resp=3 cout=%0h", k, lat, r, co, exp_lat[k], k); end
      end
      run_cmd(COMP, 8'h22, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 2 || r !== 2'b01 || co !== 8'h01)
         begin n_fail++; $display("FAIL hit_k1 got lat=%0d resp=%0h cout=%0h exp lat=2 resp=1 cout=1", lat, r, co); end
      n_checks++;
      if (b !== 1'b0) begin n_fail++; $display("FAIL hit_busy_in_resp got=%0h exp=0", b); end
   endtask

   task automatic test_decompress();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      run_cmd(DECOMP, 8'h00, 8'h02, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 1 || r !== 2'b01 || dox !== 8'h33)
         begin n_fail++; $display("FAIL decomp_2 got lat=%0d resp=%0h dout=%0h exp lat=1 resp=1 dout=33", lat, r, dox); end
      n_checks++;
      if (co !== 8'h01) begin n_fail++; $display("FAIL cout_hold got=%0h exp=1", co); end
      run_cmd(DECOMP, 8'h00, 8'h03, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 1 || r !== 2'b10 || dox !== 8'h00)
         begin n_fail++; $display("FAIL decomp_3 got lat=%0d resp=%0h dout=%0h exp lat=1 resp=2 dout=0", lat, r, dox); end
      run_cmd(DECOMP, 8'h00, 8'h01, lat, r, co, dox, b, rn);
      run_cmd(DECOMP, 8'h00, 8'h42, lat, r, co, dox, b, rn);
      n_checks++;
      if (r !== 2'b10 || dox !== 8'h00)
         begin n_fail++; $display("FAIL decomp_upper got resp=%0h dout=%0h exp resp=2 dout=0", r, dox); end
      run_cmd(COMP, 8'h33, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 3 || r !== 2'b01 || co !== 8'h02 || dox !== 8'h00)
         begin n_fail++; $display("FAIL hit_k2_dout_hold got lat=%0d resp=%0h cout=%0h dout=%0h exp lat=3 resp=1 cout=2 dout=0", lat, r, co, dox); end
   endtask

   task automatic test_full();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         run_cmd(COMP, 8'(k), 8'h00, lat, r, co, dox, b, rn);
         n_checks++;
         if (lat != ((k == 0) ? 1 : k) || r !== 2'b11 || co !== 8'(k))
            begin n_fail++; $display("FAIL fill_%0d got lat=%0d resp=%0h cout=%0h exp resp=3 cout=%0h", k, lat, r, co, k); end
      end
      run_cmd(COMP, 8'h10, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 16 || r !== 2'b10 || co !== 8'h00)
         begin n_fail++; $display("FAIL full_miss got lat=%0d resp=%0h cout=%0h exp lat=16 resp=2 cout=0", lat, r, co); end
      n_checks++;
      if (dut.count_q !== 5'd16) begin n_fail++; $display("FAIL full_count got=%0d exp=16", dut.count_q); end
      run_cmd(COMP, 8'h0F, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 16 || r !== 2'b01 || co !== 8'h0F)
         begin n_fail++; $display("FAIL full_hit_last got lat=%0d resp=%0h cout=%0h exp lat=16 resp=1 cout=f", lat, r, co); end
      run_cmd(DECOMP, 8'h00, 8'h0F, lat, r, co, dox, b, rn);
      n_checks++;
      if (r !== 2'b01 || dox !== 8'h0F)
         begin n_fail++; $display("FAIL full_decomp_15 got resp=%0h dout=%0h exp resp=1 dout=f", r, dox); end
   endtask

   task automatic test_clear();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      run_cmd(CLR, 8'h00, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 1 || r !== 2'b01)
         begin n_fail++; $display("FAIL clear got lat=%0d resp=%0h exp lat=1 resp=1", lat, r); end
      run_cmd(DECOMP, 8'h00, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (r !== 2'b10) begin n_fail++; $display("FAIL clear_decomp0 got resp=%0h exp=2", r); end
      run_cmd(COMP, 8'h0F, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (lat != 1 || r !== 2'b11 || co !== 8'h00)
         begin n_fail++; $display("FAIL clear_reinsert got lat=%0d resp=%0h cout=%0h exp lat=1 resp=3 cout=0", lat, r, co); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      int n_resp = 0;
      do_reset();
      fill(8, 8'h20);
      @(negedge clk);
      command = COMP; data_in = 8'h55;
      @(posedge clk); #1;
      command = NOP;
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk); #1;
         if (response !== 2'b00) n_resp++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || response !== 2'b00 || dut.count_q !== 5'd0)
         begin n_fail++; $display("FAIL reset_mid got busy=%0h resp=%0h count=%0d exp 0 0 0", busy, response, dut.count_q); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (response !== 2'b00) n_resp++;
      end
      n_checks++;
      if (n_resp != 0) begin n_fail++; $display("FAIL reset_mid_no_resp got=%0d exp=0", n_resp); end
      run_cmd(DECOMP, 8'h00, 8'h00, lat, r, co, dox, b, rn);
      n_checks++;
      if (r !== 2'b10) begin n_fail++; $display("FAIL reset_mid_decomp0 got resp=%0h exp=2", r); end
   endtask

   task automatic test_busy_ignore();
      int lat; logic [1:0] r, rn; logic [7:0] co, dox; logic b;
      int n_resp = 0;
      int resp_at = -1;
      logic [1:0] resp_val = 2'b00;
      logic [7:0] cout_val = 8'h00;
      int busy_bad = 0;
      do_reset();
      fill(4, 8'h30);
      @(negedge clk);
      command = COMP; data_in = 8'h77;
      @(posedge clk); #1;
      data_in = 8'h99;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k <= 3 && busy !== 1'b1) busy_bad++;
         if (response !== 2'b00) begin
            n_resp++;
            if (resp_at < 0) begin resp_at = k; resp_val = response; cout_val = compressed_out; end
         end
         if (k == 3) command = NOP;
      end
      n_checks++;
      if (busy_bad != 0) begin n_fail++; $display("FAIL busy_high got_low_cycles=%0d exp=0", busy_bad); end
      n_checks++;
      if (n_resp != 1 || resp_at != 4)
         begin n_fail++; $display("FAIL busy_ignore got n_resp=%0d at=%0d exp n_resp=1 at=4", n_resp, resp_at); end
      n_checks++;
      if (resp_val !== 2'b11 || cout_val !== 8'h04)
         begin n_fail++; $display("FAIL busy_ignore_result got resp=%0h cout=%0h exp resp=3 cout=4", resp_val, cout_val); end
      run_cmd(DECOMP, 8'h00, 8'h04, lat, r, co, dox, b, rn);
      n_checks++;
      if (r !== 2'b01 || dox !== 8'h77)
         begin n_fail++; $display("FAIL key_latched got resp=%0h dout=%0h exp resp=1 dout=77", r, dox); end
      n_checks++;
      if (dut.count_q !== 5'd5) begin n_fail++; $display("FAIL busy_ignore_count got=%0d exp=5", dut.count_q); end
   endtask

   initial begin
      test_reset();
      test_first_insert();
      test_hit();
      test_decompress();
      test_full();
      test_clear();
      test_reset_mid();
      test_busy_ignore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
